// File: rtl/bc_pkg.sv
// Shared encodings for the bc_updown_mod up/down counter slice.
package bc_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/bc_updown_mod_if.sv
// Control/status bundle of the up/down counter; master drives controls, slave is the counter.
interface bc_updown_mod_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] limit;
    logic [1:0]       mode;
    logic             start;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             at_zero;
    logic             at_limit;
    logic             busy;
    logic             done;

    modport master (
        output en, up, load, load_data, limit, mode, start,
        input  count, tc, at_zero, at_limit, busy, done
    );

    modport slave (
        input  en, up, load, load_data, limit, mode, start,
        output count, tc, at_zero, at_limit, busy, done
    );
endinterface

// File: rtl/bc_prescaler.sv
// Step prescaler: emits a tick on every PRESCALE-th enabled cycle; clr restarts the phase.
module bc_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] RELOAD = PW'(PRESCALE - 1);

    logic [PW-1:0] remain;

    assign tick = en && (remain == '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            remain <= RELOAD;
        end else if (en) begin
            remain <= (remain == '0) ? RELOAD : remain - PW'(1);
        end
    end
endmodule

// File: rtl/bc_updown_mod.sv
// Up/down counter with runtime modulo limit, WRAP/SATURATE/ONESHOT modes and a tc pulse.
// Define BC_PRESCALE_EN to insert a step prescaler of PRESCALE enabled cycles.
module bc_updown_mod
    import bc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input logic             clk,
    input logic             rst,
    bc_updown_mod_if.slave  bus
);
    // state | meaning
    // IDLE  | one-shot not armed, count holds
    // RUN   | one-shot counting toward its boundary
    // DONE  | boundary reached, count holds until start/load
    logic [1:0]       state;
    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             zl_pulsed;

    logic             is_one;
    logic             eligible;
    logic             step;
    logic             limit_zero;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] sat_nxt;
    logic [WIDTH-1:0] sat_target;
    logic             sat_hit;

    assign is_one     = (bus.mode == MODE_ONESHOT);
    assign eligible   = bus.en && (!is_one || state == ST_RUN);
    assign limit_zero = (bus.limit == '0);
    assign load_val   = (bus.load_data > bus.limit) ? bus.limit : bus.load_data;

`ifdef BC_PRESCALE_EN
    logic tick;

    bc_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.load || (bus.start && is_one)),
        .en   (eligible),
        .tick (tick)
    );

    assign step = tick;
`else
    assign step = eligible;
`endif

    // A count above a lowered limit clamps straight to the limit on an up-step.
    assign sat_nxt    = bus.up ? ((count_q >= bus.limit) ? bus.limit : count_q + WIDTH'(1))
                               : ((count_q == '0) ? '0 : count_q - WIDTH'(1));
    assign sat_target = bus.up ? bus.limit : '0;
    assign sat_hit    = (sat_nxt == sat_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            tc_q      <= 1'b0;
            state     <= ST_IDLE;
            zl_pulsed <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (!limit_zero) zl_pulsed <= 1'b0;
            if (bus.load) begin
                count_q   <= load_val;
                state     <= ST_IDLE;
                zl_pulsed <= 1'b0;
            end else if (bus.start && is_one) begin
                count_q   <= bus.up ? '0 : bus.limit;
                state     <= ST_RUN;
                zl_pulsed <= 1'b0;
            end else if (step) begin
                if (bus.mode == MODE_SAT || is_one) begin
                    count_q <= sat_nxt;
                    if (is_one) begin
                        if (sat_hit) begin
                            tc_q  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else begin
                        // With limit 0 the count never moves, so remember the single pulse.
                        tc_q <= sat_hit && (sat_nxt != count_q || (limit_zero && !zl_pulsed));
                        if (limit_zero) zl_pulsed <= 1'b1;
                    end
                end else if (bus.up) begin
                    if (count_q >= bus.limit) begin
                        count_q <= '0;
                        tc_q    <= 1'b1;
                    end else begin
                        count_q <= count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_q <= bus.limit;
                        tc_q    <= 1'b1;
                    end else begin
                        count_q <= count_q - WIDTH'(1);
                    end
                end
            end
            if (!is_one) state <= ST_IDLE;
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc_q;
    assign bus.at_zero  = (count_q == '0);
    assign bus.at_limit = (count_q >= bus.limit);
    assign bus.busy     = (state == ST_RUN);
    assign bus.done     = (state == ST_DONE);
endmodule

// File: tb/tb_bc_updown_mod.sv
// Self-checking bench for bc_updown_mod: directed vector table plus randomized run against a reference model.
module tb_bc_updown_mod;
    localparam int W  = 4;
    localparam int PS = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bc_updown_mod_if #(.WIDTH(W)) bus ();

    bc_updown_mod #(.WIDTH(W), .PRESCALE(PS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit r, en, up, ld;
        int ldv, lim, mode;
        bit st;
        int cnt;
        bit tc, busy, done;
    } vec_t;

    vec_t vq[$];

    // reference model state
    int m_cnt = 0;
    bit m_tc = 0, m_run = 0, m_fin = 0, m_zl = 0;
    int m_ps = 0;

    function automatic vec_t v(bit r, bit en, bit up, bit ld, int ldv, int lim, int mode, bit st,
                               int cnt, bit tc, bit busy, bit done);
        vec_t x;
        x.r = r; x.en = en; x.up = up; x.ld = ld; x.ldv = ldv; x.lim = lim; x.mode = mode; x.st = st;
        x.cnt = cnt; x.tc = tc; x.busy = busy; x.done = done;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_update(bit r, bit en, bit up, bit ld, int ldv, int lim, int mode, bit st);
        bit one;
        bit step;
        int nxt;
        int target;
        one  = (mode == 2);
        m_tc = 0;
        if (r) begin
            m_cnt = 0; m_run = 0; m_fin = 0; m_zl = 0; m_ps = 0;
            return;
        end
        if (lim != 0) m_zl = 0;
        if (ld) begin
            m_cnt = (ldv < lim) ? ldv : lim;
            m_run = 0; m_fin = 0; m_zl = 0; m_ps = 0;
        end else if (st && one) begin
            m_cnt = up ? 0 : lim;
            m_run = 1; m_fin = 0; m_zl = 0; m_ps = 0;
        end else begin
            step = en && (!one || m_run);
`ifdef BC_PRESCALE_EN
            if (step) begin
                m_ps++;
                if (m_ps == PS) m_ps = 0;
                else step = 0;
            end
`endif
            if (step) begin
                if (mode == 1 || one) begin
                    nxt    = up ? ((m_cnt + 1 > lim) ? lim : m_cnt + 1) : ((m_cnt == 0) ? 0 : m_cnt - 1);
                    target = up ? lim : 0;
                    if (one) begin
                        if (nxt == target) begin
                            m_tc = 1; m_run = 0; m_fin = 1;
                        end
                    end else begin
                        m_tc = (nxt == target) && (nxt != m_cnt || (lim == 0 && !m_zl));
                        if (lim == 0) m_zl = 1;
                    end
                    m_cnt = nxt;
                end else if (up) begin
                    if (m_cnt >= lim) begin m_cnt = 0; m_tc = 1; end
                    else m_cnt = m_cnt + 1;
                end else begin
                    if (m_cnt == 0) begin m_cnt = lim; m_tc = 1; end
                    else m_cnt = m_cnt - 1;
                end
            end
        end
        if (!one) begin m_run = 0; m_fin = 0; end
    endtask

    // Drive one cycle's inputs, advance the model, and sample just after the edge.
    task automatic cycle(bit r, bit en, bit up, bit ld, int ldv, int lim, int mode, bit st);
        rst           = r;
        bus.en        = en;
        bus.up        = up;
        bus.load      = ld;
        bus.load_data = W'(ldv);
        bus.limit     = W'(lim);
        bus.mode      = 2'(mode);
        bus.start     = st;
        model_update(r, en, up, ld, ldv, lim, mode, st);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(string tag, int cnt, bit tc, bit busy, bit done, int lim);
        chk({tag, ".count"},    32'(bus.count),    cnt);
        chk({tag, ".tc"},       32'(bus.tc),       32'(tc));
        chk({tag, ".busy"},     32'(bus.busy),     32'(busy));
        chk({tag, ".done"},     32'(bus.done),     32'(done));
        chk({tag, ".at_zero"},  32'(bus.at_zero),  32'(cnt == 0));
        chk({tag, ".at_limit"}, 32'(bus.at_limit), 32'(cnt >= lim));
    endtask

    initial begin
        int r_mode, r_lim;
        bit r_up;
`ifndef BC_PRESCALE_EN
        vq.push_back(v(1,1,1,1,9,5,2,1, 0,0,0,0));
        // WRAP, limit 5, up then down
        vq.push_back(v(0,1,1,0,0,5,0,0, 1,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 2,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 3,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 4,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 5,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 0,1,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 1,0,0,0));
        vq.push_back(v(0,0,1,1,0,5,0,0, 0,0,0,0));
        vq.push_back(v(0,1,0,0,0,5,0,0, 5,1,0,0));
        vq.push_back(v(0,1,0,0,0,5,0,0, 4,0,0,0));
        // SATURATE, limit 3
        vq.push_back(v(0,0,1,1,0,3,1,0, 0,0,0,0));
        vq.push_back(v(0,1,1,0,0,3,1,0, 1,0,0,0));
        vq.push_back(v(0,1,1,0,0,3,1,0, 2,0,0,0));
        vq.push_back(v(0,1,1,0,0,3,1,0, 3,1,0,0));
        vq.push_back(v(0,1,1,0,0,3,1,0, 3,0,0,0));
        vq.push_back(v(0,1,1,0,0,3,1,0, 3,0,0,0));
        vq.push_back(v(0,1,1,0,0,3,1,0, 3,0,0,0));
        vq.push_back(v(0,1,0,0,0,3,1,0, 2,0,0,0));
        vq.push_back(v(0,1,0,0,0,3,1,0, 1,0,0,0));
        vq.push_back(v(0,1,0,0,0,3,1,0, 0,1,0,0));
        vq.push_back(v(0,1,0,0,0,3,1,0, 0,0,0,0));
        vq.push_back(v(0,1,0,0,0,3,1,0, 0,0,0,0));
        // ONESHOT, limit 4
        vq.push_back(v(0,0,1,0,0,4,2,1, 0,0,1,0));
        vq.push_back(v(0,1,1,0,0,4,2,0, 1,0,1,0));
        vq.push_back(v(0,1,1,0,0,4,2,0, 2,0,1,0));
        vq.push_back(v(0,1,1,0,0,4,2,0, 3,0,1,0));
        vq.push_back(v(0,1,1,0,0,4,2,0, 4,1,0,1));
        vq.push_back(v(0,1,1,0,0,4,2,0, 4,0,0,1));
        vq.push_back(v(0,1,1,0,0,4,2,0, 4,0,0,1));
        vq.push_back(v(0,0,1,0,0,4,2,1, 0,0,1,0));
        vq.push_back(v(0,1,1,0,0,4,2,0, 1,0,1,0));
        vq.push_back(v(0,1,1,1,2,4,2,0, 2,0,0,0));
        vq.push_back(v(0,1,1,0,0,4,2,0, 2,0,0,0));
        // direction change mid-run retargets to 0
        vq.push_back(v(0,0,1,0,0,5,2,1, 0,0,1,0));
        vq.push_back(v(0,1,1,0,0,5,2,0, 1,0,1,0));
        vq.push_back(v(0,1,1,0,0,5,2,0, 2,0,1,0));
        vq.push_back(v(0,1,0,0,0,5,2,0, 1,0,1,0));
        vq.push_back(v(0,1,0,0,0,5,2,0, 0,1,0,1));
        // load clamp and priority
        vq.push_back(v(0,0,1,1,9,6,0,0, 6,0,0,0));
        vq.push_back(v(0,1,1,1,2,6,0,0, 2,0,0,0));
        vq.push_back(v(0,1,1,0,0,6,0,0, 3,0,0,0));
        // reset aborts a run
        vq.push_back(v(0,0,1,0,0,6,2,1, 0,0,1,0));
        vq.push_back(v(0,1,1,0,0,6,2,0, 1,0,1,0));
        vq.push_back(v(1,1,1,1,9,6,2,1, 0,0,0,0));
        // limit lowered below count, then limit 0
        vq.push_back(v(0,0,1,1,7,10,0,0, 7,0,0,0));
        vq.push_back(v(0,1,1,0,0,3,0,0, 0,1,0,0));
        vq.push_back(v(0,1,1,0,0,0,0,0, 0,1,0,0));
        vq.push_back(v(0,1,1,0,0,0,0,0, 0,1,0,0));
        vq.push_back(v(0,1,0,0,0,0,0,0, 0,1,0,0));
        vq.push_back(v(0,1,1,0,0,0,1,0, 0,1,0,0));
        vq.push_back(v(0,1,1,0,0,0,1,0, 0,0,0,0));
        vq.push_back(v(0,1,0,0,0,0,1,0, 0,0,0,0));
        vq.push_back(v(0,0,1,1,7,10,1,0, 7,0,0,0));
        vq.push_back(v(0,1,1,0,0,3,1,0, 3,1,0,0));
        vq.push_back(v(0,1,1,0,0,3,1,0, 3,0,0,0));
        // ONESHOT with limit 0, then leaving the mode
        vq.push_back(v(0,0,0,0,0,0,2,1, 0,0,1,0));
        vq.push_back(v(0,1,0,0,0,0,2,0, 0,1,0,1));
        vq.push_back(v(0,1,0,0,0,0,2,0, 0,0,0,1));
        vq.push_back(v(0,0,1,0,0,0,0,0, 0,0,0,0));
`else
        vq.push_back(v(1,0,1,0,0,5,0,0, 0,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 0,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 0,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 1,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 1,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 1,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 2,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 2,0,0,0));
        vq.push_back(v(0,0,1,0,0,5,0,0, 2,0,0,0));
        vq.push_back(v(0,0,1,0,0,5,0,0, 2,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 2,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 3,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 3,0,0,0));
        vq.push_back(v(0,0,1,1,0,5,0,0, 0,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 0,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 0,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 1,0,0,0));
        vq.push_back(v(0,0,1,1,5,5,0,0, 5,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 5,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 5,0,0,0));
        vq.push_back(v(0,1,1,0,0,5,0,0, 0,1,0,0));
`endif
        for (int i = 0; i < vq.size(); i++) begin
            cycle(vq[i].r, vq[i].en, vq[i].up, vq[i].ld, vq[i].ldv, vq[i].lim, vq[i].mode, vq[i].st);
            check_outputs($sformatf("vec%0d", i), vq[i].cnt, vq[i].tc, vq[i].busy, vq[i].done, vq[i].lim);
        end

        r_mode = 0;
        r_lim  = 9;
        r_up   = 1;
        for (int i = 0; i < 1500; i++) begin
            bit r, en, ld, st;
            int ldv;
            if ($urandom_range(0, 19) == 0) r_mode = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0)
                r_lim = ($urandom_range(0, 3) == 0) ? 0 : (($urandom_range(0, 1) == 1) ? 15 : $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) r_up = ~r_up;
            r   = ($urandom_range(0, 63) == 0);
            ld  = ($urandom_range(0, 11) == 0);
            st  = ($urandom_range(0, 9) == 0);
            en  = ($urandom_range(0, 3) != 0);
            ldv = $urandom_range(0, 15);
            cycle(r, en, r_up, ld, ldv, r_lim, r_mode, st);
            check_outputs($sformatf("rnd%0d", i), m_cnt, m_tc, m_run, m_fin, r_lim);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
